// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the dmem arbiter: FSM state encoding and port ids.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_MEM  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  localparam logic ARB_P0 = 1'b0;
  localparam logic ARB_P1 = 1'b1;

endpackage

// File: rtl/arb2_sel.sv
// Two-input winner select. Build option: DMEM_ARB_RR_EN selects round-robin,
// otherwise fixed priority with port 0 first.
module arb2_sel
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

`ifdef DMEM_ARB_RR_EN
  // On a tie the port that did not win last time goes first.
  always_comb begin
    win = req;
    if (req == 2'b11)
      win = (last == ARB_P0) ? 2'b10 : 2'b01;
  end
`else
  logic unused_last;
  assign unused_last = last;
  assign win = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the core LSU (port 0) and a secondary
// master (port 1). Build option: DMEM_ARB_RR_EN enables round-robin ties.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADDR_SIZE-1:0] m0_addr,
  input  logic [XLEN-1:0]      m0_wdata,
  input  logic [ADDR_SIZE-1:0] m0_pc,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [XLEN-1:0]      m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDR_SIZE-1:0] m1_addr,
  input  logic [XLEN-1:0]      m1_wdata,
  input  logic [ADDR_SIZE-1:0] m1_pc,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [XLEN-1:0]      m1_rdata,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_a,
  output logic [XLEN-1:0]      mem_wd,
  output logic [ADDR_SIZE-1:0] mem_pc,
  input  logic [XLEN-1:0]      mem_rd
);

  arb_state_e           state;
  logic                 owner;
  logic                 we_q;
  logic [ADDR_SIZE-1:0] a_q, pc_q;
  logic [XLEN-1:0]      wd_q, rsp_q;
  logic                 last_q;
  logic [1:0]           win;
  logic                 idle;

  assign idle = (state == ARB_IDLE) & ~reset;

  arb2_sel u_sel (
    .req  ({m1_req, m0_req}),
    .last (last_q),
    .win  (win)
  );

  assign m0_gnt = idle & win[0];
  assign m1_gnt = idle & win[1];

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)                 last_q <= ARB_P1;
    else if (m0_gnt | m1_gnt)  last_q <= m1_gnt ? ARB_P1 : ARB_P0;
  end
`else
  assign last_q = ARB_P1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      owner <= ARB_P0;
      we_q  <= 1'b0;
      a_q   <= '0;
      wd_q  <= '0;
      pc_q  <= '0;
      rsp_q <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (|win) begin
          owner <= win[1] ? ARB_P1 : ARB_P0;
          we_q  <= win[1] ? m1_we    : m0_we;
          a_q   <= win[1] ? m1_addr  : m0_addr;
          wd_q  <= win[1] ? m1_wdata : m0_wdata;
          pc_q  <= win[1] ? m1_pc    : m0_pc;
          state <= ARB_MEM;
        end
        // Read data is sampled before the write lands, so stores return the old word.
        ARB_MEM: begin
          rsp_q <= mem_rd;
          state <= ARB_RSP;
        end
        ARB_RSP: state <= ARB_IDLE;
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign mem_we = (state == ARB_MEM) & we_q & ~reset;
  assign mem_a  = a_q;
  assign mem_wd = wd_q;
  assign mem_pc = pc_q;

  assign m0_rvalid = (state == ARB_RSP) & (owner == ARB_P0);
  assign m1_rvalid = (state == ARB_RSP) & (owner == ARB_P1);
  assign m0_rdata  = m0_rvalid ? rsp_q : '0;
  assign m1_rdata  = m1_rvalid ? rsp_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small dmem model and response scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m0_pc = '0;
  logic [31:0] m1_addr = '0, m1_wdata = '0, m1_pc = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_a, mem_wd, mem_pc, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.XLEN(32), .ADDR_SIZE(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_pc(m0_pc),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_pc(m1_pc),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_pc(mem_pc), .mem_rd(mem_rd)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(i));
  endfunction

  // dmem stand-in: combinational read, write on the clock edge
  logic [31:0] ram [0:63];
  logic        load_ram = 1'b1;
  assign mem_rd = ram[mem_a[7:2]];
  always @(posedge clk) begin
    if (load_ram) for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    else if (mem_we) ram[mem_a[7:2]] <= mem_wd;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    int          idx;
    logic [31:0] wdata;
    logic [31:0] data;
    int          gcyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        me;
  logic [31:0] model [0:63];
  int          gnt_port_q[$], gnt_cyc_q[$], we_cyc_q[$], rsp_cyc_q[$];
  int          rsp_cnt = 0;
  logic [31:0] last_data = '0;

  // Scoreboard: expectation pushed at grant, checked at rvalid.
  always @(negedge clk) begin
    if (reset) exp_q.delete();
    else begin
      check("one_gnt", {31'b0, m0_gnt & m1_gnt}, 32'd0);
      if (mem_we) we_cyc_q.push_back(cyc);
      if (m0_rvalid | m1_rvalid) begin
        check("one_rvalid", {31'b0, m0_rvalid & m1_rvalid}, 32'd0);
        if (exp_q.size() == 0)
          check("rsp_unexpected", {31'b0, m0_rvalid | m1_rvalid}, 32'd0);
        else begin
          me = exp_q.pop_front();
          check("rsp_port", {31'b0, m1_rvalid}, me.port);
          check("rsp_latency", cyc, me.gcyc + 2);
          check("rsp_data", m1_rvalid ? m1_rdata : m0_rdata, me.data);
          check("nonowner_rdata", m1_rvalid ? m0_rdata : m1_rdata, 32'd0);
          if (me.we) model[me.idx] = me.wdata;
          last_data = m1_rvalid ? m1_rdata : m0_rdata;
          rsp_cnt++;
          rsp_cyc_q.push_back(cyc);
        end
      end
      if (m0_gnt | m1_gnt) begin
        me.port  = m1_gnt ? 1 : 0;
        me.we    = m1_gnt ? m1_we : m0_we;
        me.idx   = m1_gnt ? int'(m1_addr[7:2]) : int'(m0_addr[7:2]);
        me.wdata = m1_gnt ? m1_wdata : m0_wdata;
        me.data  = model[me.idx];
        me.gcyc  = cyc;
        exp_q.push_back(me);
        gnt_port_q.push_back(me.port);
        gnt_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] a,
                       input logic [31:0] d, output int gc);
    if (p == 0) begin
      m0_we = we; m0_addr = a; m0_wdata = d; m0_pc = 32'h1000 + a; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_addr = a; m1_wdata = d; m1_pc = '0; m1_req = 1'b1;
    end
    gc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((p == 0 && m0_gnt) || (p == 1 && m1_gnt)) begin
        gc = cyc;
        break;
      end
      step();
    end
    step();
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("gnt_seen", {31'b0, gc >= 0}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int g, t, n0;

  initial begin
    for (int i = 0; i < 64; i++) model[i] = init_word(i);

    // Reset: a pending request must not be granted while reset is high
    m0_req = 1'b1;
    repeat (3) step();
    load_ram = 1'b0;
    @(negedge clk);
    check("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    check("rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    check("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
    check("rst_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_m1_rdata", m1_rdata, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    check("rst_mem_pc", mem_pc, 32'd0);
    step();
    m0_req = 1'b0;
    reset  = 1'b0;

    // Single load from 0x10
    m0_we = 1'b0; m0_addr = 32'h10; m0_pc = 32'h400; m0_req = 1'b1;
    @(negedge clk);
    check("t1_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    check("t1_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    step();
    m0_req = 1'b0;
    @(negedge clk);
    check("t1_mem_a", mem_a, 32'h10);
    check("t1_mem_pc", mem_pc, 32'h400);
    check("t1_mem_we", {31'b0, mem_we}, 32'd0);
    check("t1_early_rvalid", {31'b0, m0_rvalid}, 32'd0);
    step();
    @(negedge clk);
    check("t1_m0_rvalid", {31'b0, m0_rvalid}, 32'd1);
    check("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    step();

    // Port 1 store then load of 0x20
    we_cyc_q.delete();
    issue(1, 1'b1, 32'h20, 32'h12345678, g);
    step(); step();
    check("t2_we_cycles", we_cyc_q.size(), 32'd1);
    if (we_cyc_q.size() > 0) check("t2_we_at", we_cyc_q[0], g + 1);
    check("t2_ram", ram[8], 32'h12345678);
    issue(1, 1'b0, 32'h20, 32'h0, g);
    step(); step();
    check("t2_load_data", last_data, 32'h12345678);

    // Simultaneous requests held for six cycles
    gnt_port_q.delete(); gnt_cyc_q.delete();
    m0_we = 1'b0; m0_addr = 32'h04; m0_pc = 32'h1004;
    m1_we = 1'b0; m1_addr = 32'h08; m1_pc = '0;
    m0_req = 1'b1; m1_req = 1'b1;
    t = cyc;
    repeat (6) step();
    m0_req = 1'b0; m1_req = 1'b0;
    check("t3_gnt_count", gnt_port_q.size(), 32'd2);
    if (gnt_port_q.size() == 2) begin
      check("t3_gnt0_cyc", gnt_cyc_q[0], t);
      check("t3_gnt1_cyc", gnt_cyc_q[1], t + 3);
      check("t3_gnt0_port", gnt_port_q[0], 32'd0);
`ifdef DMEM_ARB_RR_EN
      check("t3_gnt1_port", gnt_port_q[1], 32'd1);
`else
      check("t3_gnt1_port", gnt_port_q[1], 32'd0);
`endif
    end

    // Busy collision: port 1 asks while port 0 is in flight
    t = cyc;
    m0_we = 1'b0; m0_addr = 32'h14; m0_req = 1'b1;
    @(negedge clk);
    check("t4_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    step();
    m0_req = 1'b0;
    m1_we = 1'b0; m1_addr = 32'h0C; m1_req = 1'b1;
    @(negedge clk);
    check("t4_wait_mem", {31'b0, m1_gnt}, 32'd0);
    step();
    @(negedge clk);
    check("t4_wait_rsp", {31'b0, m1_gnt}, 32'd0);
    step();
    @(negedge clk);
    check("t4_m1_gnt", {31'b0, m1_gnt}, 32'd1);
    check("t4_gnt_cyc", cyc, t + 3);
    step();
    m1_req = 1'b0;
    step(); step();

    // Reset during the MEM cycle of a port 0 store to 0x30
    n0 = rsp_cnt;
    issue(0, 1'b1, 32'h30, 32'hCAFEF00D, g);
    reset = 1'b1;
    @(negedge clk);
    check("t5_we_gated", {31'b0, mem_we}, 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t5_ram_kept", ram[12], init_word(12));
    check("t5_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
    check("t5_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    check("t5_mem_we", {31'b0, mem_we}, 32'd0);
    check("t5_m0_rdata", m0_rdata, 32'd0);
    check("t5_mem_a", mem_a, 32'd0);
    check("t5_mem_wd", mem_wd, 32'd0);
    check("t5_mem_pc", mem_pc, 32'd0);
    step();
    @(negedge clk);
    check("t5_no_rvalid", {31'b0, m0_rvalid | m1_rvalid}, 32'd0);
    check("t5_rsp_cnt", rsp_cnt, n0);
    step();

    // Ten back-to-back port 0 loads
    rsp_cyc_q.delete();
    n0 = rsp_cnt;
    for (int k = 0; k < 10; k++) issue(0, 1'b0, 32'h40 + 32'(4 * k), 32'h0, g);
    step(); step();
    check("t6_rsp_count", rsp_cnt - n0, 32'd10);
    if (rsp_cyc_q.size() == 10)
      for (int k = 1; k < 10; k++)
        check("t6_rsp_spacing", rsp_cyc_q[k] - rsp_cyc_q[k-1], 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
